// File: rtl/read_resp_slave_if.sv
// Write/read bus of the read-response slave: write strobe, read request strobe,
// and the qualified response returned by the slave.
interface read_resp_slave_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
);
  logic          wvalid;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          rvalid;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic          rresp;
  logic          rerr;
  logic [15:0]   rd_count;

  modport master (
    output wvalid, waddr, wdata, rvalid, raddr,
    input  rdata, rresp, rerr, rd_count
  );

  modport slave (
    input  wvalid, waddr, wdata, rvalid, raddr,
    output rdata, rresp, rerr, rd_count
  );
endinterface

// File: rtl/read_resp_slave.sv
// Storage slave with write-first read sampling, a LATENCY-deep response
// pipeline, per-entry written flags and a saturating read-request counter.
module read_resp_slave #(
  parameter int unsigned LATENCY = 0,
  parameter int unsigned AW      = 4,
  parameter int unsigned DW      = 8
) (
  input logic              clock,
  input logic              reset,
  read_resp_slave_if.slave bus
);
  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0]    mem_q [Depth];
  logic [Depth-1:0] written_q;
  logic [15:0]      rd_count_q;

  logic          rd_acc;
  logic [DW-1:0] samp_data;
  logic          samp_err;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_err;

  assign rd_acc = bus.rvalid & ~reset;

  // Write-first: a same-cycle write to the read address is forwarded.
  always_comb begin
    samp_data = '0;
    samp_err  = 1'b1;
    if (bus.wvalid && (bus.waddr == bus.raddr)) begin
      samp_data = bus.wdata;
      samp_err  = 1'b0;
    end else if (written_q[bus.raddr]) begin
      samp_data = mem_q[bus.raddr];
      samp_err  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && bus.wvalid) begin
      mem_q[bus.waddr] <= bus.wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      written_q <= '0;
    end else if (bus.wvalid) begin
      written_q[bus.waddr] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_count_q <= '0;
    end else if (bus.rvalid && (rd_count_q != 16'hFFFF)) begin
      rd_count_q <= rd_count_q + 16'd1;
    end
  end

  if (LATENCY == 0) begin : g_comb
    assign out_valid = rd_acc;
    assign out_data  = samp_data;
    assign out_err   = samp_err;
  end else begin : g_pipe
    logic [LATENCY-1:0] pipe_v_q;
    logic [DW-1:0]      pipe_d_q [LATENCY];
    logic [LATENCY-1:0] pipe_e_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        pipe_v_q <= '0;
      end else begin
        pipe_v_q[0] <= rd_acc;
        for (int i = 1; i < LATENCY; i++) begin
          pipe_v_q[i] <= pipe_v_q[i-1];
        end
      end
    end

    // Payload carries no reset; it is only observed when its valid bit is set.
    always_ff @(posedge clock) begin
      pipe_d_q[0] <= samp_data;
      pipe_e_q[0] <= samp_err;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_d_q[i] <= pipe_d_q[i-1];
        pipe_e_q[i] <= pipe_e_q[i-1];
      end
    end

    assign out_valid = pipe_v_q[LATENCY-1];
    assign out_data  = pipe_d_q[LATENCY-1];
    assign out_err   = pipe_e_q[LATENCY-1];
  end

  // Responses are suppressed while reset is held so nothing in flight escapes.
  always_comb begin
    bus.rresp    = out_valid & ~reset;
    bus.rdata    = bus.rresp ? out_data : '0;
    bus.rerr     = bus.rresp & out_err;
    bus.rd_count = rd_count_q;
  end
endmodule
